// File: rtl/block_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// block_add_ctrl_pkg
//   Shared constants and state encoding for the block-accumulate tile sequencer.
//   Revision: 1.0
// ============================================================================
package block_add_ctrl_pkg;

    localparam int c_DATA_W = 16;
    localparam int c_J      = 2;
    localparam int c_K      = 2;
    localparam int c_A_M    = 4;
    localparam int c_B_N    = 4;
    localparam int c_DIM_W  = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_REQ    = 3'd2,
        ST_ADD    = 3'd3,
        ST_SETTLE = 3'd4,
        ST_DONE   = 3'd5
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/block_tile_iter.sv
`default_nettype none
// ============================================================================
// block_tile_iter
//   Row/column/step counters for a JxK tile walk; step innermost, then column,
//   then row. o_last flags the final step of the final tile.
//   Revision: 1.0
// ============================================================================
module block_tile_iter
    import block_add_ctrl_pkg::*;
#(
    parameter int DIM_W = c_DIM_W,
    parameter int J     = c_J,
    parameter int K     = c_K
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_advance,
    input  logic [DIM_W-1:0] i_rows,
    input  logic [DIM_W-1:0] i_cols,
    input  logic [DIM_W-1:0] i_depth,
    output logic [DIM_W-1:0] o_row,
    output logic [DIM_W-1:0] o_col,
    output logic [DIM_W-1:0] o_step,
    output logic             o_last
);

    localparam logic [DIM_W:0] c_J_EXT   = (DIM_W+1)'(J);
    localparam logic [DIM_W:0] c_K_EXT   = (DIM_W+1)'(K);
    localparam logic [DIM_W:0] c_ONE_EXT = (DIM_W+1)'(1);

    logic [DIM_W-1:0] r_row;
    logic [DIM_W-1:0] r_col;
    logic [DIM_W-1:0] r_step;

    logic [DIM_W:0]   w_row_sum;
    logic [DIM_W:0]   w_col_sum;
    logic [DIM_W:0]   w_step_inc;
    logic             w_step_wrap;
    logic             w_col_wrap;
    logic             w_row_wrap;

    // One extra bit keeps coordinate + tile size from wrapping near 2**DIM_W.
    assign w_row_sum   = {1'b0, r_row}  + c_J_EXT;
    assign w_col_sum   = {1'b0, r_col}  + c_K_EXT;
    assign w_step_inc  = {1'b0, r_step} + c_ONE_EXT;

    assign w_step_wrap = (w_step_inc >= {1'b0, i_depth});
    assign w_col_wrap  = (w_col_sum  >= {1'b0, i_cols});
    assign w_row_wrap  = (w_row_sum  >= {1'b0, i_rows});

    assign o_last = w_step_wrap && w_col_wrap && w_row_wrap;
    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_step = r_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row  <= '0;
            r_col  <= '0;
            r_step <= '0;
        end else if (i_clear) begin
            r_row  <= '0;
            r_col  <= '0;
            r_step <= '0;
        end else if (i_advance) begin
            if (w_step_wrap) begin
                r_step <= '0;
                if (w_col_wrap) begin
                    r_col <= '0;
                    r_row <= w_row_sum[DIM_W-1:0];
                end else begin
                    r_col <= w_col_sum[DIM_W-1:0];
                end
            end else begin
                r_step <= w_step_inc[DIM_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/block_add_ctrl.sv
`default_nettype none
// ============================================================================
// block_add_ctrl
//   Tile sequencer: validates a matrix-accumulate command, requests one
//   multiplied block per tile step and commits each through block_add.
//   Revision: 1.0
// ============================================================================
module block_add_ctrl
    import block_add_ctrl_pkg::*;
#(
    parameter int DIM_W = c_DIM_W,
    parameter int J     = c_J,
    parameter int K     = c_K,
    parameter int A_M   = c_A_M,
    parameter int B_N   = c_B_N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [DIM_W-1:0] i_cmd_rows,
    input  logic [DIM_W-1:0] i_cmd_cols,
    input  logic [DIM_W-1:0] i_cmd_depth,
    input  logic             i_abort,
    output logic             o_mul_req,
    output logic [DIM_W-1:0] o_mul_row,
    output logic [DIM_W-1:0] o_mul_col,
    output logic [DIM_W-1:0] o_mul_step,
    input  logic             i_mul_ack,
    output logic             o_add_start,
    output logic [DIM_W-1:0] o_add_row,
    output logic [DIM_W-1:0] o_add_col,
    output logic [DIM_W-1:0] o_add_num_cols,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    localparam logic [DIM_W:0] c_A_M_EXT = (DIM_W+1)'(A_M);
    localparam logic [DIM_W:0] c_B_N_EXT = (DIM_W+1)'(B_N);

    ctrl_state_t      r_state;
    ctrl_state_t      w_state_nxt;

    logic [DIM_W-1:0] r_rows;
    logic [DIM_W-1:0] r_cols;
    logic [DIM_W-1:0] r_depth;

    logic             r_cmd_ready;
    logic             r_busy;
    logic             r_mul_req;
    logic             r_add_start;
    logic             r_done;
    logic             r_err;
    logic [DIM_W-1:0] r_add_row;
    logic [DIM_W-1:0] r_add_col;

    logic [DIM_W-1:0] w_row;
    logic [DIM_W-1:0] w_col;
    logic [DIM_W-1:0] w_step;
    logic             w_last;
    logic             w_accept;
    logic             w_bad;
    logic             w_it_clear;
    logic             w_it_advance;

    assign w_accept = (r_state == ST_IDLE) && i_cmd_valid && r_cmd_ready;

    assign w_bad = (r_rows  == '0) ||
                   (r_cols  == '0) ||
                   (r_depth == '0) ||
                   ({1'b0, r_rows} > c_A_M_EXT) ||
                   ({1'b0, r_cols} > c_B_N_EXT);

    // Counters restart on entry to a command and whenever the walk ends, so
    // coordinates never carry over from an aborted or finished command.
    assign w_it_clear   = (r_state == ST_CHECK) ||
                          (w_state_nxt == ST_IDLE) ||
                          (w_state_nxt == ST_DONE);
    assign w_it_advance = (r_state == ST_SETTLE) && (w_state_nxt == ST_REQ);

    block_tile_iter #(
        .DIM_W (DIM_W),
        .J     (J),
        .K     (K)
    ) u_tile_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_it_clear),
        .i_advance (w_it_advance),
        .i_rows    (r_rows),
        .i_cols    (r_cols),
        .i_depth   (r_depth),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_step    (w_step),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = ST_CHECK;
            ST_CHECK:  w_state_nxt = w_bad ? ST_DONE : ST_REQ;
            ST_REQ:    if (i_mul_ack) w_state_nxt = ST_ADD;
            ST_ADD:    w_state_nxt = ST_SETTLE;
            ST_SETTLE: w_state_nxt = w_last ? ST_DONE : ST_REQ;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        // Abort overrides everything, including an ack arriving in the same cycle.
        if (i_abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rows  <= '0;
            r_cols  <= '0;
            r_depth <= '0;
        end else if (w_accept) begin
            r_rows  <= i_cmd_rows;
            r_cols  <= i_cmd_cols;
            r_depth <= i_cmd_depth;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_mul_req   <= 1'b0;
            r_add_start <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_add_row   <= '0;
            r_add_col   <= '0;
        end else begin
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_mul_req   <= (w_state_nxt == ST_REQ);
            r_add_start <= (w_state_nxt == ST_ADD);
            r_done      <= (w_state_nxt == ST_DONE);
            r_err       <= (w_state_nxt == ST_DONE) && (r_state == ST_CHECK);
            if (w_state_nxt == ST_ADD) begin
                r_add_row <= w_row;
                r_add_col <= w_col;
            end
        end
    end

    assign o_cmd_ready    = r_cmd_ready;
    assign o_busy         = r_busy;
    assign o_mul_req      = r_mul_req;
    assign o_mul_row      = w_row;
    assign o_mul_col      = w_col;
    assign o_mul_step     = w_step;
    assign o_add_start    = r_add_start;
    assign o_add_row      = r_add_row;
    assign o_add_col      = r_add_col;
    assign o_add_num_cols = r_cols;
    assign o_done         = r_done;
    assign o_err          = r_err;

endmodule
`default_nettype wire
